// File: rtl/dmem_access_unit_if.sv
// Bus bundle for the load/store unit: CPU request/response and word-memory port.
// The master side is the CPU plus the memory, and the slave side is the access unit.
interface dmem_access_unit_if;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [31:0] cpu_addr;
  logic [1:0]  cpu_size;
  logic        cpu_unsigned;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        cpu_misalign;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_size, cpu_unsigned, cpu_wdata, mem_rdata,
    input  cpu_rdata, cpu_stall, cpu_misalign, mem_rd, mem_wr, mem_addr, mem_wdata
  );

  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_size, cpu_unsigned, cpu_wdata, mem_rdata,
    output cpu_rdata, cpu_stall, cpu_misalign, mem_rd, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_access_unit.sv
// Load/store front end to a word-wide data memory: lane extraction/extension on loads,
// two-cycle read-modify-write for byte/halfword stores, and misalignment detection.
module dmem_access_unit #(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input logic               clk,
  input logic               reset,
  dmem_access_unit_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } state_t;

  state_t      state_r;
  state_t      next_state_s;
  logic [31:0] merge_r;
  logic [31:0] merge_next_s;
  logic        misalign_s;
  logic        req_s;
  logic        is_word_s;

  // Byte lane index in the memory word for a given byte offset.
  function automatic logic [1:0] byte_lane(input logic [1:0] addr_lo);
    logic [1:0] lane;
    if (BIG_ENDIAN) begin
      lane = ~addr_lo;
    end else begin
      lane = addr_lo;
    end
    return lane;
  endfunction

  // Halfword lane index in the memory word for a given byte offset.
  function automatic logic half_lane(input logic [1:0] addr_lo);
    logic lane;
    if (BIG_ENDIAN) begin
      lane = ~addr_lo[1];
    end else begin
      lane = addr_lo[1];
    end
    return lane;
  endfunction

  // Extract the addressed lane and extend it to 32 bits.
  function automatic logic [31:0] load_extend(
    input logic [31:0] word,
    input logic [1:0]  addr_lo,
    input logic [1:0]  size,
    input logic        zext
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{byte_lane(addr_lo), 3'b000} +: 8];
    h = word[{half_lane(addr_lo), 4'b0000} +: 16];
    case (size)
      2'b00:   res = zext ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   res = zext ? {16'd0, h} : {{16{h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Replace the addressed lane(s) of the old word with right-justified store data.
  function automatic logic [31:0] merge_lanes(
    input logic [31:0] word,
    input logic [1:0]  addr_lo,
    input logic [1:0]  size,
    input logic [31:0] wdata
  );
    logic [31:0] res;
    res = word;
    case (size)
      2'b00:   res[{byte_lane(addr_lo), 3'b000} +: 8]   = wdata[7:0];
      2'b01:   res[{half_lane(addr_lo), 4'b0000} +: 16] = wdata[15:0];
      default: res = wdata;
    endcase
    return res;
  endfunction

  // Request classification; reserved size 11 behaves as a word.
  always_comb begin
    req_s     = bus.cpu_rd | bus.cpu_wr;
    is_word_s = bus.cpu_size[1];
    case (bus.cpu_size)
      2'b00:   misalign_s = 1'b0;
      2'b01:   misalign_s = bus.cpu_addr[0];
      default: misalign_s = (bus.cpu_addr[1:0] != 2'b00);
    endcase
  end

  // State and merge-word registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      merge_r <= 32'd0;
    end else begin
      state_r <= next_state_s;
      merge_r <= merge_next_s;
    end
  end

  // Next state and outputs; everything is held at zero while reset is asserted.
  always_comb begin
    next_state_s     = state_r;
    merge_next_s     = merge_r;
    bus.cpu_rdata    = 32'd0;
    bus.cpu_stall    = 1'b0;
    bus.cpu_misalign = 1'b0;
    bus.mem_rd       = 1'b0;
    bus.mem_wr       = 1'b0;
    bus.mem_addr     = 32'd0;
    bus.mem_wdata    = 32'd0;
    if (!reset) begin
      next_state_s = IDLE;
    end else begin
      bus.mem_addr = {2'b00, bus.cpu_addr[31:2]};
      case (state_r)
        IDLE: begin
          if (req_s && misalign_s) begin
            bus.cpu_misalign = 1'b1;
          end else if (bus.cpu_wr) begin
            if (is_word_s) begin
              bus.mem_wr    = 1'b1;
              bus.mem_wdata = bus.cpu_wdata;
            end else begin
              bus.mem_rd    = 1'b1;
              bus.cpu_stall = 1'b1;
              merge_next_s  = merge_lanes(bus.mem_rdata, bus.cpu_addr[1:0],
                                          bus.cpu_size, bus.cpu_wdata);
              next_state_s  = RMW_WR;
            end
          end else if (bus.cpu_rd) begin
            bus.mem_rd    = 1'b1;
            bus.cpu_rdata = load_extend(bus.mem_rdata, bus.cpu_addr[1:0],
                                        bus.cpu_size, bus.cpu_unsigned);
          end else begin
            next_state_s = IDLE;
          end
        end
        RMW_WR: begin
          // The held request is not re-decoded; only the merged word is written.
          bus.mem_wr    = 1'b1;
          bus.mem_wdata = merge_r;
          next_state_s  = IDLE;
        end
        default: begin
          next_state_s = IDLE;
        end
      endcase
    end
  end

endmodule
